// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge: samples AHB NONSEQ/SEQ transfers and
// replays them as registered APB setup/enable pairs on one of three selects.
module ahb2apb_bridge (
    input  logic        clock,
    input  logic        Hresetn,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [2:0]  Hsize,
    input  logic [2:0]  Hburst,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata,
    output logic        Hreadyout,
    output logic [1:0]  Hresp,
    output logic [31:0] Hrdata,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic        Pwrite,
    output logic        Penable,
    output logic [3:0]  Pselx
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WWAIT, ST_READ, ST_WRITE,
        ST_WRITEP, ST_RENABLE, ST_WENABLE, ST_WENABLEP
    } state_e;

    function automatic logic [3:0] decode(input logic [31:0] addr);
        case (addr[31:26])
            6'b100000: decode = 4'b0001;
            6'b100001: decode = 4'b0010;
            6'b100010: decode = 4'b0100;
            default:   decode = 4'b0000;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [31:0] haddr1_q, haddr2_q, hwdata1_q, hwdata2_q;
    logic        hwrite_q;
    logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d;
    logic        pwrite_q, pwrite_d, penable_q, penable_d, hreadyout_q, hreadyout_d;
    logic [3:0]  pselx_q, pselx_d;
    logic        valid;
    logic        unused_inputs;

    assign valid         = Hreadyin & Htrans[1] & (decode(Haddr) != 4'b0000);
    assign unused_inputs = ^{Hsize, Hburst, hwdata2_q};

    // Address/data history so a write's data phase can be paired with its address.
    always_ff @(posedge clock or posedge Hresetn) begin
        if (Hresetn) begin
            haddr1_q  <= '0;
            haddr2_q  <= '0;
            hwdata1_q <= '0;
            hwdata2_q <= '0;
            hwrite_q  <= 1'b0;
        end else if (Hreadyin) begin
            haddr1_q  <= Haddr;
            haddr2_q  <= haddr1_q;
            hwdata1_q <= Hwdata;
            hwdata2_q <= hwdata1_q;
            hwrite_q  <= Hwrite;
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold default first so no path infers a latch.
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        penable_d   = penable_q;
        pselx_d     = pselx_q;
        hreadyout_d = hreadyout_q;

        case (state_q)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (valid && Hwrite)  state_d = ST_WWAIT;
                else if (valid)       state_d = ST_READ;
                else                  state_d = ST_IDLE;
            end
            ST_WWAIT:    state_d = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:     state_d = ST_RENABLE;
            ST_WRITE:    state_d = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP:   state_d = ST_WENABLEP;
            ST_WENABLEP: begin
                if (!hwrite_q)        state_d = ST_READ;
                else if (valid)       state_d = ST_WRITEP;
                else                  state_d = ST_WRITE;
            end
            default:     state_d = ST_IDLE;
        endcase

        // Outputs are a function of the state being entered.
        case (state_d)
            ST_READ: begin
                paddr_d     = Haddr;
                pselx_d     = decode(Haddr);
                pwrite_d    = 1'b0;
                penable_d   = 1'b0;
                hreadyout_d = 1'b0;
            end
            ST_WRITE, ST_WRITEP: begin
                paddr_d     = haddr1_q;
                pwdata_d    = Hwdata;
                pselx_d     = decode(haddr1_q);
                pwrite_d    = 1'b1;
                penable_d   = 1'b0;
                hreadyout_d = 1'b0;
            end
            ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                penable_d   = 1'b1;
                hreadyout_d = 1'b1;
                if (state_q == ST_WRITEP) begin
                    paddr_d  = haddr2_q;
                    pwdata_d = hwdata1_q;
                end
            end
            ST_IDLE, ST_WWAIT: begin
                pselx_d     = 4'b0000;
                penable_d   = 1'b0;
                hreadyout_d = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or posedge Hresetn) begin
        if (Hresetn) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            penable_q   <= 1'b0;
            pselx_q     <= 4'b0000;
            hreadyout_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            penable_q   <= penable_d;
            pselx_q     <= pselx_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Pwrite    = pwrite_q;
    assign Penable   = penable_q;
    assign Pselx     = pselx_q;
    assign Hreadyout = hreadyout_q;
    assign Hresp     = 2'b00;
    assign Hrdata    = Prdata;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Bench for ahb2apb_bridge: directed timing steps plus random AHB traffic
// scored against a transaction-level queue of expected APB transfers.
module tb_ahb2apb_bridge;

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

    logic        clock;
    logic        Hresetn, Hwrite, Hreadyin;
    logic [1:0]  Htrans;
    logic [2:0]  Hsize, Hburst;
    logic [31:0] Haddr, Hwdata, Prdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata, Paddr, Pwdata;
    logic        Pwrite, Penable;
    logic [3:0]  Pselx;

    logic        hold_off;
    logic [31:0] rd_value;
    int          checks;
    int          errors;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        write;
        logic [3:0]  sel;
    } apb_xfer_t;

    apb_xfer_t exp_q[$];

    ahb2apb_bridge dut (
        .clock(clock), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
        .Htrans(Htrans), .Hsize(Hsize), .Hburst(Hburst), .Haddr(Haddr),
        .Hwdata(Hwdata), .Prdata(Prdata), .Hreadyout(Hreadyout), .Hresp(Hresp),
        .Hrdata(Hrdata), .Paddr(Paddr), .Pwdata(Pwdata), .Pwrite(Pwrite),
        .Penable(Penable), .Pselx(Pselx)
    );

    // Single-slave AHB interconnect and a simple APB slave returning rd_value.
    assign Hreadyin = Hreadyout & ~hold_off;
    assign Prdata   = (Penable && !Pwrite && Pselx != 4'b0000) ? rd_value : 32'hDEAD_BEEF;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode: three 64 MB windows starting at 0x8000_0000.
    function automatic logic [3:0] model_sel(input logic [31:0] addr);
        if (addr < 32'h8000_0000 || addr > 32'h8BFF_FFFF) return 4'b0000;
        return 4'b0001 << ((addr - 32'h8000_0000) / 32'h0400_0000);
    endfunction

    task automatic push_if_valid(input logic [31:0] addr, input logic [31:0] data,
                                 input logic write, input logic [1:0] trans);
        logic [3:0] s;
        s = model_sel(addr);
        if (trans[1] && s != 4'b0000)
            exp_q.push_back('{addr: addr, data: data, write: write, sel: s});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advance until one AHB phase is accepted; returns Hrdata seen in that cycle.
    task automatic ahb_step(output logic [31:0] rdata);
        bit rdy;
        rdy   = 1'b0;
        rdata = '0;
        for (int i = 0; i < 16 && !rdy; i++) begin
            rdy   = (Hreadyin === 1'b1);
            rdata = Hrdata;
            tick();
        end
        check("hready_wait", 32'(rdy), 32'd1);
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] trans);
        logic [31:0] dummy;
        push_if_valid(addr, data, 1'b1, trans);
        Haddr = addr; Htrans = trans; Hwrite = 1'b1; Hburst = 3'b000;
        ahb_step(dummy);
        Htrans = T_IDLE; Haddr = '0; Hwdata = data;
        ahb_step(dummy);
        Hwdata = $urandom;
    endtask

    task automatic ahb_read(input logic [31:0] addr, input logic [1:0] trans);
        logic [31:0] rd, dummy;
        rd_value = $urandom;
        push_if_valid(addr, 32'h0, 1'b0, trans);
        Haddr = addr; Htrans = trans; Hwrite = 1'b0; Hburst = 3'b000;
        ahb_step(dummy);
        Htrans = T_IDLE; Haddr = '0;
        ahb_step(rd);
        if (trans[1] && model_sel(addr) != 4'b0000) check("read_data", rd, rd_value);
    endtask

    // Pipelined incrementing write burst: each step carries the next address and previous data.
    task automatic ahb_burst_write(input logic [31:0] base, input int beats, input logic [31:0] data [4]);
        logic [31:0] dummy;
        Hburst = 3'b011;
        for (int b = 0; b <= beats; b++) begin
            if (b < beats) begin
                Haddr  = base + 32'(4 * b);
                Htrans = (b == 0) ? T_NONSEQ : T_SEQ;
                Hwrite = 1'b1;
                push_if_valid(Haddr, data[b], 1'b1, Htrans);
            end else begin
                Htrans = T_IDLE;
                Haddr  = '0;
            end
            if (b > 0) Hwdata = data[b - 1];
            ahb_step(dummy);
        end
        Hburst = 3'b000;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || Pselx != 4'b0000) && n < 40) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(n < 40), 32'd1);
    endtask

    // APB monitor: each select must show one setup cycle, then one enable cycle,
    // and the transfer must match the head of the expected queue.
    initial begin
        bit        in_setup;
        apb_xfer_t seen, exp;
        in_setup = 1'b0;
        forever begin
            @(negedge clock);
            if (Hresetn) begin
                in_setup = 1'b0;
            end else begin
                check("hresp_okay", 32'(Hresp), 32'd0);
                if (in_setup) begin
                    in_setup = 1'b0;
                    check("enable_after_setup", 32'(Penable), 32'd1);
                    check("enable_sel_held", 32'(Pselx), 32'(seen.sel));
                    check("enable_addr_held", Paddr, seen.addr);
                    check("enable_dir_held", 32'(Pwrite), 32'(seen.write));
                    if (seen.write) check("enable_wdata_held", Pwdata, seen.data);
                    check("apb_xfer_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        exp = exp_q.pop_front();
                        check("apb_addr", seen.addr, exp.addr);
                        check("apb_sel", 32'(seen.sel), 32'(exp.sel));
                        check("apb_dir", 32'(seen.write), 32'(exp.write));
                        if (exp.write) check("apb_wdata", seen.data, exp.data);
                    end
                end else if (Pselx != 4'b0000) begin
                    check("setup_penable_low", 32'(Penable), 32'd0);
                    in_setup = 1'b1;
                    seen = '{addr: Paddr, data: Pwdata, write: Pwrite, sel: Pselx};
                end else if (Penable) begin
                    check("penable_without_sel", 32'(Penable), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] burst_data [4];
        logic [31:0] addr;
        logic [1:0]  trans;
        int          kind;
        int          beats;

        checks = 0; errors = 0;
        Hresetn = 1'b1; hold_off = 1'b0; rd_value = '0;
        Hwrite = 1'b0; Htrans = T_IDLE; Hsize = 3'b010; Hburst = 3'b000;
        Haddr = '0; Hwdata = '0;

        // Reset held for two cycles.
        repeat (2) tick();
        check("rst_pselx", 32'(Pselx), 32'h0);
        check("rst_penable", 32'(Penable), 32'h0);
        check("rst_hreadyout", 32'(Hreadyout), 32'h1);
        check("rst_hresp", 32'(Hresp), 32'h0);
        check("rst_paddr", Paddr, 32'h0);
        Hresetn = 1'b0;
        tick();

        // Single write: setup two cycles after the address, enable one later.
        Haddr = 32'h8000_0000; Htrans = T_NONSEQ; Hwrite = 1'b1;
        push_if_valid(Haddr, 32'hA5A5_A5A5, 1'b1, Htrans);
        tick();
        check("wr_wait_nosel", 32'(Pselx), 32'h0);
        check("wr_wait_ready", 32'(Hreadyout), 32'h1);
        Htrans = T_IDLE; Haddr = '0; Hwdata = 32'hA5A5_A5A5;
        tick();
        check("wr_setup_sel", 32'(Pselx), 32'h1);
        check("wr_setup_addr", Paddr, 32'h8000_0000);
        check("wr_setup_wdata", Pwdata, 32'hA5A5_A5A5);
        check("wr_setup_pwrite", 32'(Pwrite), 32'h1);
        check("wr_setup_penable", 32'(Penable), 32'h0);
        Hwdata = 32'h0;
        tick();
        check("wr_enable_penable", 32'(Penable), 32'h1);
        check("wr_enable_sel", 32'(Pselx), 32'h1);
        tick();
        check("wr_done_sel", 32'(Pselx), 32'h0);
        check("wr_done_penable", 32'(Penable), 32'h0);

        // Single read: setup in the next cycle, enable and read data one after.
        rd_value = 32'h1234_5678;
        Haddr = 32'h8400_0010; Htrans = T_NONSEQ; Hwrite = 1'b0;
        push_if_valid(Haddr, 32'h0, 1'b0, Htrans);
        tick();
        check("rd_setup_sel", 32'(Pselx), 32'h2);
        check("rd_setup_addr", Paddr, 32'h8400_0010);
        check("rd_setup_pwrite", 32'(Pwrite), 32'h0);
        check("rd_setup_penable", 32'(Penable), 32'h0);
        check("rd_setup_ready", 32'(Hreadyout), 32'h0);
        Htrans = T_IDLE; Haddr = '0;
        tick();
        check("rd_enable_penable", 32'(Penable), 32'h1);
        check("rd_enable_sel", 32'(Pselx), 32'h2);
        check("rd_enable_ready", 32'(Hreadyout), 32'h1);
        check("rd_hrdata", Hrdata, 32'h1234_5678);
        tick();
        check("rd_done_sel", 32'(Pselx), 32'h0);

        // INCR4 write burst.
        burst_data = '{32'd1, 32'd2, 32'd3, 32'd4};
        ahb_burst_write(32'h8800_0000, 4, burst_data);
        drain();

        // Negative cases: out of range, IDLE transfer, Hreadyin low.
        Haddr = 32'h9000_0000; Htrans = T_NONSEQ; Hwrite = 1'b1;
        tick();
        Htrans = T_IDLE; Hwdata = 32'h1111_1111;
        tick();
        check("neg_range_sel", 32'(Pselx), 32'h0);
        check("neg_range_penable", 32'(Penable), 32'h0);
        check("neg_range_ready", 32'(Hreadyout), 32'h1);
        Haddr = 32'h8000_0100; Htrans = T_IDLE; Hwrite = 1'b1;
        repeat (2) tick();
        check("neg_idle_sel", 32'(Pselx), 32'h0);
        check("neg_idle_penable", 32'(Penable), 32'h0);
        hold_off = 1'b1; Htrans = T_NONSEQ;
        repeat (2) tick();
        check("neg_notready_sel", 32'(Pselx), 32'h0);
        hold_off = 1'b0; Htrans = T_IDLE;
        tick();
        check("neg_notready_after", 32'(Pselx), 32'h0);

        // Window edges.
        ahb_write(32'h7FFF_FFFC, 32'hCAFE_0001, T_NONSEQ);
        ahb_write(32'h8BFF_FFFC, 32'hCAFE_0002, T_NONSEQ);
        ahb_read(32'h8C00_0000, T_NONSEQ);
        ahb_read(32'h83FF_FFFC, T_NONSEQ);
        ahb_write(32'h8400_0000, 32'hCAFE_0003, T_NONSEQ);
        ahb_read(32'h8800_0000, T_BUSY);
        drain();

        // Asynchronous reset during the enable cycle of a write.
        Haddr = 32'h8000_0040; Htrans = T_NONSEQ; Hwrite = 1'b1;
        push_if_valid(Haddr, 32'h5555_AAAA, 1'b1, Htrans);
        tick();
        Htrans = T_IDLE; Haddr = '0; Hwdata = 32'h5555_AAAA;
        tick();
        tick();
        check("rstmid_pre_penable", 32'(Penable), 32'h1);
        @(negedge clock);
        #2;
        Hresetn = 1'b1;
        #1;
        check("rstmid_penable", 32'(Penable), 32'h0);
        check("rstmid_pselx", 32'(Pselx), 32'h0);
        check("rstmid_pwrite", 32'(Pwrite), 32'h0);
        check("rstmid_paddr", Paddr, 32'h0);
        check("rstmid_pwdata", Pwdata, 32'h0);
        check("rstmid_ready", 32'(Hreadyout), 32'h1);
        tick();
        Hresetn = 1'b0;
        ahb_read(32'h8800_0100, T_NONSEQ);
        drain();

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            kind  = int'($urandom_range(0, 5));
            trans = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : T_NONSEQ;
            if (kind == 5 || $urandom_range(0, 4) == 0) begin
                addr = $urandom & 32'hFFFF_FFFC;
                if (model_sel(addr) != 4'b0000) addr = addr + 32'h1000_0000;
            end else begin
                addr = 32'h8000_0000 + 32'($urandom_range(0, 2)) * 32'h0400_0000
                     + (32'($urandom_range(0, 32'h03FF_FFE0)) & 32'hFFFF_FFFC);
            end
            case (kind)
                0, 1: ahb_write(addr, $urandom, trans);
                2, 3: ahb_read(addr, trans);
                4: begin
                    beats = int'($urandom_range(2, 4));
                    for (int b = 0; b < 4; b++) burst_data[b] = $urandom;
                    ahb_burst_write(addr, beats, burst_data);
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) ahb_write(addr, $urandom, trans);
                    else                           ahb_read(addr, trans);
                end
            endcase
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb2apb_bridge.md
Name: ahb2apb_bridge

Overview:
- Single-clock AHB-Lite slave to APB master bridge.
- Converts AHB NONSEQ/SEQ reads and writes, including burst writes, into APB setup/enable transfers.
- Decodes the target onto one of three one-hot APB selects.
- Hrdata passes Prdata straight through; Hresp is always OKAY.

Parameters:
- None. All widths are fixed: 32-bit address and data, 4-bit Pselx.

Ports:
- clock  in  1  system clock, rising edge.
- Hresetn  in  1  asynchronous, active-high reset (asserted when 1, despite the suffix).
- Hwrite  in  1  1=write, 0=read.
- Hreadyin  in  1  AHB ready; a transfer is sampled only when it is 1.
- Htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- Hsize  in  3  transfer size; accepted but unused.
- Hburst  in  3  burst type; accepted but unused.
- Haddr  in  32  AHB address.
- Hwdata  in  32  AHB write data, one cycle after its address.
- Prdata  in  32  APB read data.
- Hreadyout  out  1  bridge ready to AHB.
- Hresp  out  2  constant 2'b00.
- Hrdata  out  32  combinational copy of Prdata.
- Paddr  out  32  APB address.
- Pwdata  out  32  APB write data.
- Pwrite  out  1  APB direction.
- Penable  out  1  APB enable.
- Pselx  out  4  one-hot APB select, bit 3 unused (always 0).

Behaviour:
- valid = Hreadyin & Htrans[1] & (Haddr in 0x8000_0000..0x8BFF_FFFF).
- Select decode: 0x8000_0000..0x83FF_FFFF -> 0001; 0x8400_0000..0x87FF_FFFF -> 0010; 0x8800_0000..0x8BFF_FFFF -> 0100; otherwise 0000 and valid=0.
- Pipeline registers, updated every cycle while Hreadyin=1: Haddr1<=Haddr, Haddr2<=Haddr1, Hwdata1<=Hwdata, Hwdata2<=Hwdata1, Hwrite_r<=Hwrite.
- FSM states: IDLE, WWAIT, READ, WRITE, WRITEP, RENABLE, WENABLE, WENABLEP. Reset state is IDLE.
- Transitions:
  - IDLE: valid&Hwrite -> WWAIT; valid&!Hwrite -> READ; else IDLE.
  - WWAIT: valid -> WRITEP; else WRITE.
  - READ -> RENABLE.
  - WRITE: valid -> WENABLEP; else WENABLE.
  - WRITEP -> WENABLEP.
  - RENABLE and WENABLE: valid&Hwrite -> WWAIT; valid&!Hwrite -> READ; else IDLE.
  - WENABLEP: !Hwrite_r -> READ; valid&Hwrite_r -> WRITEP; !valid&Hwrite_r -> WRITE.
- All APB outputs and Hreadyout are registered. Each is set on the edge entering a state:
  - Entering READ: Paddr=Haddr, Pselx=decode(Haddr), Pwrite=0, Penable=0, Hreadyout=0.
  - Entering WWAIT: Pselx=0, Penable=0, Hreadyout=1 (waits for write data).
  - Entering WRITE or WRITEP: Paddr=Haddr1, Pwdata=Hwdata, Pselx=decode(Haddr1), Pwrite=1, Penable=0, Hreadyout=0.
  - Entering WENABLEP from WRITEP: Paddr=Haddr2, Pwdata=Hwdata1.
  - Entering RENABLE, WENABLE or WENABLEP: Penable=1, Pselx held, Hreadyout=1.
  - Entering IDLE from an ENABLE state: Pselx=0, Penable=0, Hreadyout=1.
- Latency:
  - Read: address sampled at edge N; setup phase (Psel=1, Penable=0) in cycle N+1; access phase (Penable=1) in N+2; Hrdata valid in N+2.
  - Write: address at edge N; setup at N+2; enable at N+3.
- APB transfers have no wait states; Pready is not used. Every setup phase lasts exactly one cycle, followed by exactly one enable cycle.
- Out-of-range addresses or IDLE/BUSY Htrans: no APB activity, Hreadyout stays 1, Hresp stays 00.
- Reset asserted mid-transfer: immediately Penable=0, Pselx=0, Pwrite=0, Paddr=0, Pwdata=0, Hreadyout=1, FSM=IDLE, pipeline registers=0.

Test Plan:
- Reset: Hresetn=1 for 2 cycles -> Pselx=0000, Penable=0, Hreadyout=1, Hresp=00, Paddr=0.
- Single write: Haddr=0x8000_0000, Htrans=10, Hwrite=1, next cycle Hwdata=0xA5A5_A5A5 -> setup phase with Pselx=0001, Paddr=0x8000_0000, Pwdata=0xA5A5_A5A5, Pwrite=1; Penable=1 the following cycle.
- Single read: Haddr=0x8400_0010, Hwrite=0, Prdata=0x1234_5678 -> Pselx=0010, Pwrite=0, Penable=1 in N+2, Hrdata=0x1234_5678.
- INCR4 write burst (Htrans NONSEQ,SEQ,SEQ,SEQ) at 0x8800_0000 with data 1,2,3,4 -> four APB writes in order to 0x8800_0000/04/08/0C with data 1..4, Pselx=0100, each with one setup and one enable cycle.
- Negative cases: Haddr=0x9000_0000 with Htrans=10, or Htrans=00 (IDLE) at a valid address -> Pselx stays 0000, Penable=0.
- Reset mid-write: assert Hresetn during WENABLE -> Penable and Pselx drop in the same cycle (asynchronously); the next valid read after release proceeds normally.
